riscv_single_cycle_lsu: RTL and testbench
=========================================

Name: riscv_single_cycle_lsu

Overview:
- Load/store unit directly downstream of the single-cycle datapath's data-memory port.
- Takes the core's combinational address, store data and funct3, and converts them into a registered valid/ready bus transaction with byte enables.
- Returns the load result already aligned and sign/zero-extended.
- Stalls the core (freezes PC and writeback) until the access completes, faults, or times out.

Parameters:
- TIMEOUT_CYCLES, 256: max cycles spent in REQ+RSP before abort; 0 disables the timeout.
- ENABLE_SUBWORD, 1: when 0, byte/halfword accesses are not supported and fault instead of issuing.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-low reset
- req_valid  input  1  core requests a load/store this instruction; held stable while stall=1
- req_we  input  1  1=store, 0=load
- req_funct3  input  3  RISC-V load/store funct3
- req_addr  input  32  effective address (ALU result)
- req_wdata  input  32  store data (rs2)
- stall  output  1  core must hold PC and suppress writeback
- load_data  output  32  extended load result; valid in DONE
- fault  output  1  access failed (misaligned, illegal funct3, timeout); valid in DONE
- bus_req_valid  output  1  bus request valid
- bus_req_ready  input  1  bus accepts request
- bus_we  output  1  bus write
- bus_addr  output  32  word-aligned address {req_addr[31:2],2'b00}
- bus_be  output  4  byte enables
- bus_wdata  output  32  lane-replicated store data
- bus_rsp_valid  input  1  response/ack; one per accepted request, loads and stores alike
- bus_rsp_rdata  input  32  read word

Behaviour:
- States: IDLE, REQ, RSP, DONE.
- Reset (rst=0 at posedge) forces:
  - state=IDLE, timeout counter=0;
  - bus_req_valid, bus_we, bus_addr, bus_be, bus_wdata, load_data, fault all 0.
- Reset mid-transaction aborts immediately with no completion. The bus fabric shares the same reset, so no stale response is expected.
- stall is combinational: req_valid && state!=DONE.
- IDLE with req_valid=1: decode the request.
  - Fault when any of the following holds; go to DONE with fault=1, load_data=0, no bus activity:
    - funct3 illegal (loads: 011, 110, 111; stores: anything other than 000/001/010);
    - halfword with addr[0]=1;
    - word with addr[1:0]!=0;
    - ENABLE_SUBWORD=0 with a byte or half access.
  - Otherwise register bus_addr, bus_we, bus_be and bus_wdata, and go to REQ.
- IDLE with req_valid=0: stay in IDLE.
- Byte enables and write data:
  - byte: be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}
  - half: be=4'b0011<<addr[1:0], wdata={2{wdata[15:0]}}
  - word: be=4'b1111, wdata=wdata
  - Loads drive the same be and wdata=0.
- REQ: bus_req_valid=1; address, be and data are stable until the handshake.
  - On bus_req_ready: go to RSP and drop bus_req_valid on the next cycle.
- RSP: wait for bus_rsp_valid, then go to DONE.
  - Load: extract the lane at addr[1:0].
    - LB/LH sign-extend; LBU (100) and LHU (101) zero-extend; LW passes the word through.
    - Register the result into load_data.
  - Store: load_data=0.
- bus_rsp_valid outside RSP (including in the cycle of the REQ handshake) is ignored.
- Timeout: the counter increments every cycle in REQ or RSP.
  - When TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 without progress, go to DONE with fault=1 and load_data=0.
  - bus_req_valid is withdrawn; this is the only permitted drop of valid before ready.
  - The counter clears on entering IDLE.
- DONE lasts exactly one cycle: stall=0, load_data and fault are valid and the core commits. Next state is IDLE.
  - load_data and fault return to 0 on leaving DONE.
- Back-to-back: a new req_valid seen in IDLE the cycle after DONE starts a fresh access. There is no re-triggering in DONE.
- Latency: zero-wait bus (ready in the REQ cycle, response in the first RSP cycle) gives 3 stall cycles: IDLE, REQ, RSP, then DONE.
- Wait states extend REQ/RSP one cycle each.

Test Plan:
- LW, addr=0x100, ready and rsp immediate, rdata=0xDEADBEEF -> bus_addr=0x100, be=1111, stall high 3 cycles, load_data=0xDEADBEEF in DONE, fault=0.
- LB addr=0x203, rdata=0x80FF_1234 -> be=1000, load_data=0xFFFFFF80; repeat as LBU -> 0x00000080; LH addr=0x202 -> 0xFFFF80FF.
- SB addr=0x301 wdata=0x000000AB -> bus_we=1, bus_addr=0x300, be=0010, bus_wdata=0xABABABAB; completion only after bus_rsp_valid.
- LW addr=0x102 -> no bus_req_valid, DONE on cycle 1 with fault=1; funct3=011 load -> same fault.
- TIMEOUT_CYCLES=4, ready held 0 -> bus_req_valid high 4 cycles then dropped, fault=1 in DONE; with ENABLE_SUBWORD=0, SH -> fault without a bus request.
- Assert rst=0 while in RSP with ready delayed 2 cycles -> all outputs 0 and state IDLE at the next edge; back-to-back SW then LW each see the correct stall length.

Source files
------------

// File: rtl/riscv_single_cycle_lsu_if.sv
// Data-memory bus between the single-cycle LSU (master) and the memory fabric (slave).
// Carries a valid/ready request channel and a valid-only response channel.
interface riscv_single_cycle_lsu_if;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;

    modport master (
        output bus_req_valid, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata
    );

    modport slave (
        input  bus_req_valid, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_req_ready, bus_rsp_valid, bus_rsp_rdata
    );
endinterface

// File: rtl/riscv_single_cycle_lsu.sv
// Load/store unit behind a single-cycle RISC-V datapath: turns the core's combinational
// access into a registered bus transaction and stalls the core until it completes or faults.
module riscv_single_cycle_lsu #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter bit ENABLE_SUBWORD = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        fault,
    riscv_single_cycle_lsu_if.master bus
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 2;
    localparam int TIMEOUT_LAST_I = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_LAST_I);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       funct3_r;
    logic [1:0]       lane_r;
    logic [1:0]       dec_size_s;
    logic             dec_fault_s;
    logic             timeout_s;

    function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
        logic bad;
        if (we) begin
            bad = (f3[2] == 1'b1) || (f3[1:0] == 2'b11);
        end else begin
            bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        return bad;
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = 4'b0011 << lane;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic we, input logic [1:0] size,
                                               input logic [31:0] wdata);
        logic [31:0] d;
        if (!we) begin
            d = 32'h0000_0000;
        end else begin
            case (size)
                2'b00:   d = {4{wdata[7:0]}};
                2'b01:   d = {2{wdata[15:0]}};
                default: d = wdata;
            endcase
        end
        return d;
    endfunction

    // The lane is shifted down first so byte/half extraction is lane-independent.
    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [1:0] lane,
                                                input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {lane, 3'b000};
        case (f3)
            3'b000:  res = {{24{sh[7]}}, sh[7:0]};
            3'b001:  res = {{16{sh[15]}}, sh[15:0]};
            3'b010:  res = word;
            3'b100:  res = {24'h00_0000, sh[7:0]};
            3'b101:  res = {16'h0000, sh[15:0]};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    assign stall     = req_valid && (state_r != DONE);
    assign timeout_s = TIMEOUT_EN && (cnt_r == TIMEOUT_LAST);

    // Request decode: any reason the access cannot be issued on the bus.
    always_comb begin
        dec_size_s  = req_funct3[1:0];
        dec_fault_s = 1'b0;
        if (funct3_illegal(req_we, req_funct3)) begin
            dec_fault_s = 1'b1;
        end else if ((dec_size_s == 2'b01) && req_addr[0]) begin
            dec_fault_s = 1'b1;
        end else if ((dec_size_s == 2'b10) && (req_addr[1:0] != 2'b00)) begin
            dec_fault_s = 1'b1;
        end else if (!ENABLE_SUBWORD && (dec_size_s != 2'b10)) begin
            dec_fault_s = 1'b1;
        end else begin
            dec_fault_s = 1'b0;
        end
    end

    // Access FSM with registered bus and result outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r           <= IDLE;
            cnt_r             <= {CNT_W{1'b0}};
            funct3_r          <= 3'b000;
            lane_r            <= 2'b00;
            bus.bus_req_valid <= 1'b0;
            bus.bus_we        <= 1'b0;
            bus.bus_addr      <= 32'h0000_0000;
            bus.bus_be        <= 4'b0000;
            bus.bus_wdata     <= 32'h0000_0000;
            load_data         <= 32'h0000_0000;
            fault             <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r <= {CNT_W{1'b0}};
                    if (req_valid) begin
                        if (dec_fault_s) begin
                            fault     <= 1'b1;
                            load_data <= 32'h0000_0000;
                            state_r   <= DONE;
                        end else begin
                            bus.bus_req_valid <= 1'b1;
                            bus.bus_we        <= req_we;
                            bus.bus_addr      <= {req_addr[31:2], 2'b00};
                            bus.bus_be        <= lane_be(dec_size_s, req_addr[1:0]);
                            bus.bus_wdata     <= lane_wdata(req_we, dec_size_s, req_wdata);
                            funct3_r          <= req_funct3;
                            lane_r            <= req_addr[1:0];
                            state_r           <= REQ;
                        end
                    end
                end
                REQ: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    if (bus.bus_req_ready) begin
                        bus.bus_req_valid <= 1'b0;
                        state_r           <= RSP;
                    end else if (timeout_s) begin
                        bus.bus_req_valid <= 1'b0;
                        fault             <= 1'b1;
                        load_data         <= 32'h0000_0000;
                        state_r           <= DONE;
                    end
                end
                RSP: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    if (bus.bus_rsp_valid) begin
                        fault     <= 1'b0;
                        load_data <= bus.bus_we ? 32'h0000_0000
                                                : extend_load(funct3_r, lane_r, bus.bus_rsp_rdata);
                        state_r   <= DONE;
                    end else if (timeout_s) begin
                        fault     <= 1'b1;
                        load_data <= 32'h0000_0000;
                        state_r   <= DONE;
                    end
                end
                DONE: begin
                    cnt_r     <= {CNT_W{1'b0}};
                    load_data <= 32'h0000_0000;
                    fault     <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_single_cycle_lsu.sv
// Directed bench for riscv_single_cycle_lsu: a default instance plus one with a short
// timeout and subword accesses disabled, each driven by a scripted bus responder.
module tb_riscv_single_cycle_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid1, req_valid2;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        stall1, stall2, fault1, fault2;
    logic [31:0] load_data1, load_data2;

    riscv_single_cycle_lsu_if bus1();
    riscv_single_cycle_lsu_if bus2();

    riscv_single_cycle_lsu dut (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall1), .load_data(load_data1), .fault(fault1), .bus(bus1)
    );

    riscv_single_cycle_lsu #(.TIMEOUT_CYCLES(4), .ENABLE_SUBWORD(1'b0)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid2), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall2), .load_data(load_data2), .fault(fault2), .bus(bus2)
    );

    typedef struct {
        logic [31:0] data;
        logic        fault;
        int          stalls;
        int          vcyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=no end of test expected=end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic stall_of(input bit sel);
        return sel ? stall2 : stall1;
    endfunction

    function automatic logic valid_of(input bit sel);
        return sel ? bus2.bus_req_valid : bus1.bus_req_valid;
    endfunction

    function automatic logic [68:0] fields_of(input bit sel);
        return sel ? {bus2.bus_we, bus2.bus_be, bus2.bus_addr, bus2.bus_wdata}
                   : {bus1.bus_we, bus1.bus_be, bus1.bus_addr, bus1.bus_wdata};
    endfunction

    task automatic drive(input bit sel, input logic rdy, input logic rv, input logic [31:0] rd);
        if (sel) begin
            bus2.bus_req_ready = rdy; bus2.bus_rsp_valid = rv; bus2.bus_rsp_rdata = rd;
        end else begin
            bus1.bus_req_ready = rdy; bus1.bus_rsp_valid = rv; bus1.bus_rsp_rdata = rd;
        end
    endtask

    // One access: expected outcome queued at issue, popped and checked in DONE.
    task automatic access(input bit sel, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int rdy_dly, input int rsp_dly,
                          input logic [31:0] e_addr, input logic [3:0] e_be,
                          input logic [31:0] e_wdata, input logic [31:0] e_data,
                          input logic e_fault, input int e_stalls, input int e_vcyc);
        exp_t e;
        exp_t got;
        int   stalls = 0;
        int   vcyc = 0;
        int   rwait = 0;
        bit   hs = 1'b0;
        bit   in_rsp = 1'b0;
        bit   done = 1'b0;
        e.data = e_data; e.fault = e_fault; e.stalls = e_stalls; e.vcyc = e_vcyc;
        sb_q.push_back(e);
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        if (sel) req_valid2 = 1'b1; else req_valid1 = 1'b1;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            #1;
            if (!stall_of(sel)) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (hs) in_rsp = 1'b1;
                hs = 1'b0;
                if (valid_of(sel)) begin
                    vcyc++;
                    chk("bus_fields", fields_of(sel), {we, e_be, e_addr, e_wdata});
                    hs = (vcyc > rdy_dly);
                end
                drive(sel, hs, in_rsp && (rwait >= rsp_dly), rdata);
                if (in_rsp) rwait++;
                @(negedge clk);
            end
        end
        chk("reached_done", done, 1'b1);
        got.data   = sel ? load_data2 : load_data1;
        got.fault  = sel ? fault2 : fault1;
        got.stalls = stalls;
        got.vcyc   = vcyc;
        drive(sel, 1'b0, 1'b0, 32'h0000_0000);
        req_valid1 = 1'b0; req_valid2 = 1'b0;
        e = sb_q.pop_front();
        chk("load_data", got.data, e.data);
        chk("fault", got.fault, e.fault);
        chk("stall_cycles", got.stalls, e.stalls);
        chk("req_valid_cycles", got.vcyc, e.vcyc);
    endtask

    initial begin
        rst = 1'b0;
        req_valid1 = 1'b0; req_valid2 = 1'b0;
        req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", {bus1.bus_req_valid, fields_of(1'b0), load_data1, fault1}, 128'h0);
        chk("reset_outputs2", {bus2.bus_req_valid, fields_of(1'b1), load_data2, fault2}, 128'h0);
        chk("reset_stall", {stall1, stall2}, 2'b00);
        rst = 1'b1;

        // Loads: alignment of lanes and sign/zero extension.
        access(0, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0,
               32'h100, 4'hF, 32'h0, 32'hDEADBEEF, 0, 3, 1);
        access(0, 0, 3'b000, 32'h203, 32'h0, 32'h80FF1234, 0, 0,
               32'h200, 4'h8, 32'h0, 32'hFFFFFF80, 0, 3, 1);
        access(0, 0, 3'b100, 32'h203, 32'h0, 32'h80FF1234, 0, 0,
               32'h200, 4'h8, 32'h0, 32'h00000080, 0, 3, 1);
        access(0, 0, 3'b001, 32'h202, 32'h0, 32'h80FF1234, 0, 0,
               32'h200, 4'hC, 32'h0, 32'hFFFF80FF, 0, 3, 1);
        access(0, 0, 3'b101, 32'h200, 32'h0, 32'h80FF1234, 0, 0,
               32'h200, 4'h3, 32'h0, 32'h00001234, 0, 3, 1);
        access(0, 0, 3'b000, 32'h201, 32'h0, 32'h80FF1234, 0, 0,
               32'h200, 4'h2, 32'h0, 32'h00000012, 0, 3, 1);
        // Stores with wait states on both channels; read data on a store ack must be dropped.
        access(0, 1, 3'b000, 32'h301, 32'h000000AB, 32'h12345678, 1, 2,
               32'h300, 4'h2, 32'hABABABAB, 32'h0, 0, 6, 2);
        access(0, 1, 3'b001, 32'h302, 32'h0000BEEF, 32'h0, 0, 0,
               32'h300, 4'hC, 32'hBEEFBEEF, 32'h0, 0, 3, 1);
        // Faults decoded in IDLE: no bus request, DONE on the next cycle.
        access(0, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 1, 0);
        access(0, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 1, 0);
        access(0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 1, 0);
        access(0, 0, 3'b001, 32'h201, 32'h0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 1, 0);

        // Short-timeout, word-only instance.
        access(1, 0, 3'b010, 32'h40, 32'h0, 32'h0, 1000, 0,
               32'h40, 4'hF, 32'h0, 32'h0, 1, 5, 4);
        access(1, 0, 3'b010, 32'h44, 32'h0, 32'h55, 0, 1000,
               32'h44, 4'hF, 32'h0, 32'h0, 1, 5, 1);
        access(1, 1, 3'b001, 32'h0, 32'h1234, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1, 1, 0);
        access(1, 0, 3'b010, 32'h48, 32'h0, 32'h0BADF00D, 0, 0,
               32'h48, 4'hF, 32'h0, 32'h0BADF00D, 0, 3, 1);

        // Reset while waiting for a response.
        @(negedge clk);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; req_wdata = 32'h0;
        req_valid1 = 1'b1;
        @(negedge clk); #1;
        chk("rst_req_valid", bus1.bus_req_valid, 1'b1);
        @(negedge clk);
        @(negedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clk); #1;
        chk("rsp_valid_dropped", bus1.bus_req_valid, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("midtxn_reset_outputs", {bus1.bus_req_valid, fields_of(1'b0), load_data1, fault1}, 128'h0);
        chk("midtxn_reset_stall", stall1, 1'b1);
        rst = 1'b1;
        req_valid1 = 1'b0;
        @(negedge clk); #1;
        chk("post_reset_idle", {stall1, bus1.bus_req_valid}, 2'b00);

        // Back-to-back SW then LW.
        access(0, 1, 3'b010, 32'h104, 32'h11223344, 32'h0, 0, 0,
               32'h104, 4'hF, 32'h11223344, 32'h0, 0, 3, 1);
        access(0, 0, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D, 0, 0,
               32'h104, 4'hF, 32'h0, 32'hCAFEF00D, 0, 3, 1);

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
